// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline chain.
package pipe_pkg;

   // Ceiling log2, usable in constant expressions for port widths.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // A transfer happens when both sides of a handshake agree.
   function automatic logic fire(input logic valid, input logic ready);
      return valid & ready;
   endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// One elastic stage: a main register feeding downstream and a skid register
// that catches the word arriving while main is stalled. Ready is registered.
module pipe_skid_slice #(
   parameter int                N_BITS    = 32,
   parameter logic [N_BITS-1:0] RST_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              in_valid_i,
   input  logic [N_BITS-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [N_BITS-1:0] out_data_o,
   input  logic              out_ready_i
);

   logic              m_v_q, m_v_d, s_v_q, s_v_d;
   logic [N_BITS-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
   logic              accept, main_free;

   assign in_ready_o  = ~s_v_q;
   assign out_valid_o = m_v_q;
   assign out_data_o  = m_d_q;

   // Next-state: refill main from skid first, then from the input; park in skid when main stalls.
   always_comb begin
      accept    = in_valid_i & ~s_v_q;
      main_free = out_ready_i | ~m_v_q;
      m_v_d     = m_v_q;
      s_v_d     = s_v_q;
      m_d_d     = m_d_q;
      s_d_d     = s_d_q;
      if (main_free) begin
         if (s_v_q) begin
            m_v_d = 1'b1;
            m_d_d = s_d_q;
            s_v_d = 1'b0;
         end else if (accept) begin
            m_v_d = 1'b1;
            m_d_d = in_data_i;
         end else begin
            m_v_d = 1'b0;
         end
      end else if (accept) begin
         s_v_d = 1'b1;
         s_d_d = in_data_i;
      end
      // Flush only drops the valid bits; payload registers are left untouched.
      if (flush_i) begin
         m_v_d = 1'b0;
         s_v_d = 1'b0;
         m_d_d = m_d_q;
         s_d_d = s_d_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_v_q <= 1'b0;
         s_v_q <= 1'b0;
         m_d_q <= RST_VALUE;
         s_d_q <= RST_VALUE;
      end else begin
         m_v_q <= m_v_d;
         s_v_q <= s_v_d;
         m_d_q <= m_d_d;
         s_d_q <= s_d_d;
      end
   end

endmodule

// File: rtl/pipe_elastic_chain.sv
// DEPTH chained skid slices with an occupancy counter, used between CPU stages
// to replace a global stall enable with local back-pressure.
module pipe_elastic_chain
   import pipe_pkg::*;
#(
   parameter int                N_BITS    = 32,
   parameter int                DEPTH     = 1,
   parameter logic [N_BITS-1:0] RST_VALUE = '0,
   localparam int               CNT_W     = clog2(2*DEPTH+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              in_valid_i,
   input  logic [N_BITS-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [N_BITS-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic [CNT_W-1:0]  count_o
);

   localparam int CAP = 2*DEPTH;

   logic [DEPTH:0]    v_w;
   logic [DEPTH:0]    r_w;
   logic [N_BITS-1:0] d_w [DEPTH+1];
   logic [CNT_W-1:0]  count_q, count_d;
   logic              in_fire, out_fire;

   assign v_w[0]      = in_valid_i;
   assign d_w[0]      = in_data_i;
   assign in_ready_o  = r_w[0];
   assign r_w[DEPTH]  = out_ready_i;
   assign out_valid_o = v_w[DEPTH];
   assign out_data_o  = d_w[DEPTH];
   assign count_o     = count_q;

   for (genvar k = 0; k < DEPTH; k++) begin : gen_slice
      pipe_skid_slice #(
         .N_BITS    (N_BITS),
         .RST_VALUE (RST_VALUE)
      ) u_slice (
         .clk         (clk),
         .reset       (reset),
         .flush_i     (flush_i),
         .in_valid_i  (v_w[k]),
         .in_data_i   (d_w[k]),
         .in_ready_o  (r_w[k]),
         .out_valid_o (v_w[k+1]),
         .out_data_o  (d_w[k+1]),
         .out_ready_i (r_w[k+1])
      );
   end

   // Occupancy tracks boundary transfers; the CAP guard keeps it in range.
   always_comb begin
      in_fire  = fire(in_valid_i, in_ready_o);
      out_fire = fire(out_valid_o, out_ready_i);
      count_d  = count_q;
      if (in_fire && !out_fire && (count_q != CNT_W'(CAP)))
         count_d = count_q + CNT_W'(1);
      else if (!in_fire && out_fire && (count_q != '0))
         count_d = count_q - CNT_W'(1);
   end

   // Occupancy register; reset and flush both empty the chain.
   always_ff @(posedge clk) begin
      if (reset || flush_i) count_q <= '0;
      else                  count_q <= count_d;
   end

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Three chains (DEPTH 3, 2, 1) share one stimulus; a queue-based model of each
// chain is compared against its DUT every cycle, plus directed literal checks.
module tb_pipe_elastic_chain;

   localparam logic [31:0] RSTV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic        rdy_o [3];
   logic        vld_o [3];
   logic [31:0] dat_o [3];
   logic [2:0]  cnt0, cnt1;
   logic [1:0]  cnt2;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: per chain, per stage, an ordered list of held words (front = head).
   logic [31:0] sl [9][$];

   always #5 clk = ~clk;

   pipe_elastic_chain #(.N_BITS(32), .DEPTH(3), .RST_VALUE(RSTV)) u_d3 (
      .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(rdy_o[0]), .out_valid_o(vld_o[0]), .out_data_o(dat_o[0]),
      .out_ready_i(out_ready), .count_o(cnt0));
   pipe_elastic_chain #(.N_BITS(32), .DEPTH(2), .RST_VALUE(RSTV)) u_d2 (
      .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(rdy_o[1]), .out_valid_o(vld_o[1]), .out_data_o(dat_o[1]),
      .out_ready_i(out_ready), .count_o(cnt1));
   pipe_elastic_chain #(.N_BITS(32), .DEPTH(1), .RST_VALUE(RSTV)) u_d1 (
      .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(rdy_o[2]), .out_valid_o(vld_o[2]), .out_data_o(dat_o[2]),
      .out_ready_i(out_ready), .count_o(cnt2));

   function automatic int dep(input int i);
      return (i == 0) ? 3 : (i == 1) ? 2 : 1;
   endfunction

   function automatic logic [31:0] cnt_of(input int i);
      if (i == 0) return 32'(cnt0);
      if (i == 1) return 32'(cnt1);
      return 32'(cnt2);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Each stage holds at most two words; a stage takes a word when it holds fewer
   // than two, and passes its head on when the next stage (or downstream) can take it.
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         logic        rdy [3];
         logic        pop [3];
         logic [31:0] hd  [3];
         int          d;
         d = dep(i);
         if (reset) begin
            for (int j = 0; j < 3; j++) sl[i*3+j].delete();
         end else begin
            for (int j = 0; j < d; j++) begin
               rdy[j] = (sl[i*3+j].size() < 2);
               hd[j]  = (sl[i*3+j].size() > 0) ? sl[i*3+j][0] : 32'h0;
            end
            for (int j = 0; j < d; j++)
               pop[j] = (sl[i*3+j].size() > 0) && ((j == d-1) ? out_ready : rdy[j+1]);
            for (int j = 0; j < d; j++)
               if (pop[j]) void'(sl[i*3+j].pop_front());
            if (flush) begin
               for (int j = 0; j < 3; j++) sl[i*3+j].delete();
            end else begin
               if (in_valid && rdy[0]) sl[i*3].push_back(in_data);
               for (int j = 1; j < d; j++)
                  if (pop[j-1]) sl[i*3+j].push_back(hd[j-1]);
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         int d, sum;
         d   = dep(i);
         sum = 0;
         for (int j = 0; j < d; j++) sum += sl[i*3+j].size();
         chk($sformatf("count[d%0d]", d), cnt_of(i), 32'(sum));
         chk($sformatf("in_ready[d%0d]", d), 32'(rdy_o[i]), 32'(sl[i*3].size() < 2));
         chk($sformatf("out_valid[d%0d]", d), 32'(vld_o[i]), 32'(sl[i*3+d-1].size() > 0));
         if (sl[i*3+d-1].size() > 0)
            chk($sformatf("out_data[d%0d]", d), dat_o[i], sl[i*3+d-1][0]);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (chk_en) compare_all();
   endtask

   task automatic chk_reset_all(input string nm);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_data%0d", nm, i), dat_o[i], RSTV);
         chk($sformatf("%s_valid%0d", nm, i), 32'(vld_o[i]), 32'd0);
         chk($sformatf("%s_count%0d", nm, i), cnt_of(i), 32'd0);
         chk($sformatf("%s_ready%0d", nm, i), 32'(rdy_o[i]), 32'd1);
      end
   endtask

   initial begin
      int          acc, n;
      logic        fire_b, seen;
      logic [31:0] got [8];

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      cyc(); cyc();
      chk_reset_all("reset");
      chk_en = 1'b1;

      // Stream 1..4 into the DEPTH=3 chain; word 1 reaches the output three edges after presentation.
      reset = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = (k < 4);
         in_data  = (k < 4) ? 32'(k + 1) : 32'h0;
         cyc();
         if (k == 1) chk("stream_early", 32'(vld_o[0]), 32'd0);
         if (k >= 2 && k <= 5) begin
            chk($sformatf("stream_valid%0d", k), 32'(vld_o[0]), 32'd1);
            chk($sformatf("stream_word%0d", k), dat_o[0], 32'(k - 1));
         end
      end

      // Back-pressure on DEPTH=2: capacity 4, head held at 10, then drain in order.
      reset = 1'b1; in_valid = 1'b0; cyc();
      reset = 1'b0; out_ready = 1'b0; in_data = 32'd10; acc = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         fire_b   = rdy_o[1];
         cyc();
         if (fire_b) begin acc++; in_data = in_data + 32'd1; end
      end
      chk("bp_accepted", 32'(acc), 32'd4);
      chk("bp_ready", 32'(rdy_o[1]), 32'd0);
      chk("bp_count", 32'(cnt1), 32'd4);
      chk("bp_head", dat_o[1], 32'd10);
      in_valid = 1'b0; out_ready = 1'b1; n = 0;
      for (int k = 0; k < 8; k++) begin
         if (vld_o[1] && n < 8) begin got[n] = dat_o[1]; n++; end
         cyc();
      end
      chk("bp_drained", 32'(n), 32'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("bp_order%0d", k), got[k], 32'(10 + k));
      chk("bp_count_end", 32'(cnt1), 32'd0);

      // Flush while DEPTH=2 holds three words; the coincident word 99 is discarded.
      reset = 1'b1; cyc();
      reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
      for (int w = 20; w < 23; w++) begin in_data = 32'(w); cyc(); end
      chk("fl_count_before", 32'(cnt1), 32'd3);
      flush = 1'b1; in_data = 32'd99; out_ready = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", 32'(vld_o[1]), 32'd0);
      chk("fl_count", 32'(cnt1), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin cyc(); seen |= vld_o[1]; end
      chk("fl_no_99", 32'(seen), 32'd0);

      // Reset beats flush and transfers while everything is full.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin in_data = 32'(40 + k); cyc(); end
      chk("rp_full", 32'(cnt1), 32'd4);
      reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
      cyc();
      chk_reset_all("rprio");
      reset = 1'b0; flush = 1'b0;

      // DEPTH=1 full boundary: head leaves, skid moves up, nothing accepted that edge.
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 32'd30; cyc();
      in_data = 32'd31; cyc();
      chk("d1_full_count", 32'(cnt2), 32'd2);
      chk("d1_full_ready", 32'(rdy_o[2]), 32'd0);
      chk("d1_full_head", dat_o[2], 32'd30);
      out_ready = 1'b1; in_data = 32'd32;
      cyc();
      chk("d1_after_count", 32'(cnt2), 32'd1);
      chk("d1_after_ready", 32'(rdy_o[2]), 32'd1);
      chk("d1_after_head", dat_o[2], 32'd31);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk($sformatf("d1_stream%0d", k), dat_o[2], 32'(32 + k));
         chk($sformatf("d1_stream_cnt%0d", k), 32'(cnt2), 32'd1);
         in_data = 32'(33 + k);
      end

      // Random traffic with occasional flush and reset; the model checks every cycle.
      for (int k = 0; k < 10000; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         flush     = ($urandom_range(0, 199) == 0);
         reset     = ($urandom_range(0, 999) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
